// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle for mem_port_arbiter: two requester ports and the shared memory port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          r0_req, r0_we, r0_busy, r0_ack, r0_err;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;

  logic          r1_req, r1_we, r1_busy, r1_ack, r1_err;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;

  logic          m_req, m_we, m_gnt, m_rvalid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  m_gnt, m_rvalid, m_rdata,
    output r0_busy, r0_ack, r0_rdata, r0_err,
    output r1_busy, r1_ack, r1_rdata, r1_err,
    output m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output m_gnt, m_rvalid, m_rdata,
    input  r0_busy, r0_ack, r0_rdata, r0_err,
    input  r1_busy, r1_ack, r1_rdata, r1_err,
    input  m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0) and the
// load/store queue (port 1), with one-entry pending buffers and a per-transaction timeout.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t        state;
  logic [1:0]    pend;
  logic          sel, last_gnt, winner;
  logic [15:0]   tmo_cnt;
  logic          tmo_hit;

  logic [1:0]    req_vec, we_vec;
  logic [AW-1:0] addr_in   [2];
  logic [DW-1:0] wdata_in  [2];
  logic [1:0]    buf_we;
  logic [AW-1:0] buf_addr  [2];
  logic [DW-1:0] buf_wdata [2];

  logic          m_req_q, m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [1:0]    ack_q, err_q;
  logic [DW-1:0] rdata_q [2];

  assign req_vec     = {bus.r1_req, bus.r0_req};
  assign we_vec      = {bus.r1_we, bus.r0_we};
  assign addr_in[0]  = bus.r0_addr;
  assign addr_in[1]  = bus.r1_addr;
  assign wdata_in[0] = bus.r0_wdata;
  assign wdata_in[1] = bus.r1_wdata;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    winner = 1'b0;
    if (pend[0] && pend[1]) winner = ~last_gnt;
    else if (pend[1])       winner = 1'b1;
  end

  // NOTE: payload buffers carry no reset; they are only read while their pend bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (req_vec[i] && !pend[i]) begin
        buf_we[i]    <= we_vec[i];
        buf_addr[i]  <= addr_in[i];
        buf_wdata[i] <= wdata_in[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      sel       <= 1'b0;
      last_gnt  <= 1'b1;
      tmo_cnt   <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      for (int i = 0; i < 2; i++) rdata_q[i] <= '0;
    end else begin
      // A request while the buffer is occupied is dropped; the requester should honour busy.
      for (int i = 0; i < 2; i++) begin
        if (req_vec[i] && !pend[i]) pend[i] <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (|pend) begin
            sel       <= winner;
            last_gnt  <= winner;
            m_req_q   <= 1'b1;
            m_we_q    <= buf_we[winner];
            m_addr_q  <= buf_addr[winner];
            m_wdata_q <= buf_wdata[winner];
            tmo_cnt   <= '0;
            state     <= REQ;
          end
        end

        REQ: begin
          if (tmo_hit) begin
            m_req_q      <= 1'b0;
            ack_q[sel]   <= 1'b1;
            err_q[sel]   <= 1'b1;
            rdata_q[sel] <= '0;
            state        <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (bus.m_gnt) begin
              m_req_q <= 1'b0;
              if (m_we_q) begin
                ack_q[sel]   <= 1'b1;
                err_q[sel]   <= 1'b0;
                rdata_q[sel] <= '0;
                state        <= RESP;
              end else begin
                state <= WAIT;
              end
            end
          end
        end

        WAIT: begin
          if (tmo_hit) begin
            ack_q[sel]   <= 1'b1;
            err_q[sel]   <= 1'b1;
            rdata_q[sel] <= '0;
            state        <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (bus.m_rvalid) begin
              ack_q[sel]   <= 1'b1;
              err_q[sel]   <= 1'b0;
              rdata_q[sel] <= bus.m_rdata;
              state        <= RESP;
            end
          end
        end

        RESP: begin
          ack_q        <= '0;
          err_q        <= '0;
          rdata_q[sel] <= '0;
          pend[sel]    <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r0_busy  = pend[0];
  assign bus.r1_busy  = pend[1];
  assign bus.r0_ack   = ack_q[0];
  assign bus.r1_ack   = ack_q[1];
  assign bus.r0_err   = err_q[0];
  assign bus.r1_err   = err_q[1];
  assign bus.r0_rdata = rdata_q[0];
  assign bus.r1_rdata = rdata_q[1];
  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset abort, single load, contention,
// round-robin fairness, timeout and busy-violation behaviour.
module tb_mem_port_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int   ack_cnt0 = 0;
  int   ack_cnt1 = 0;
  int   both_ack = 0;
  bit   seen_99  = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Passive observer on the falling edge, where all values are settled.
  always @(negedge clk) begin
    if (bus.r0_ack) ack_cnt0++;
    if (bus.r1_ack) ack_cnt1++;
    if (bus.r0_ack && bus.r1_ack) both_ack++;
    if (bus.m_req && bus.m_addr == 32'h99) seen_99 = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
    bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.r0_req = 1; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_req = 1; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  task automatic clr_req();
    bus.r0_req = 0;
    bus.r1_req = 0;
  endtask

  task automatic test_reset();
    int a1;
    checks++;
    if ({bus.m_req, bus.m_we, bus.r0_busy, bus.r0_ack, bus.r0_err, bus.r1_busy, bus.r1_ack, bus.r1_err} !== 8'h00) begin
      errors++; $display("FAIL rst_ctrl: got %b expected 00000000",
        {bus.m_req, bus.m_we, bus.r0_busy, bus.r0_ack, bus.r0_err, bus.r1_busy, bus.r1_ack, bus.r1_err});
    end
    checks++;
    if ({bus.m_addr, bus.m_wdata, bus.r0_rdata, bus.r1_rdata} !== 128'h0) begin
      errors++; $display("FAIL rst_data: got %h expected 0", {bus.m_addr, bus.m_wdata, bus.r0_rdata, bus.r1_rdata});
    end
    // Drive port 1 into WAIT, then reset asynchronously mid-cycle.
    set_req(1, 1'b0, 32'h44, 32'h0);
    tick(); clr_req();
    tick(); bus.m_gnt = 1;
    tick(); bus.m_gnt = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_req, bus.r1_busy, bus.r1_ack, bus.m_addr} !== 35'h0) begin
      errors++; $display("FAIL rst_async: got %h expected 0", {bus.m_req, bus.r1_busy, bus.r1_ack, bus.m_addr});
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    a1 = ack_cnt1;
    bus.m_rvalid = 1; bus.m_rdata = 32'h1111_1111;
    tick(); bus.m_rvalid = 0;
    tick(); tick();
    checks++;
    if (ack_cnt1 !== a1) begin
      errors++; $display("FAIL rst_late_rvalid: got %0d acks expected %0d", ack_cnt1, a1);
    end
    // Both pending after reset: port 0 must win.
    set_req(0, 1'b1, 32'h10, 32'h5);
    set_req(1, 1'b1, 32'h20, 32'h6);
    tick(); clr_req();
    tick();
    checks++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h10) begin
      errors++; $display("FAIL rst_first_grant: got req=%b addr=%h expected req=1 addr=00000010", bus.m_req, bus.m_addr);
    end
    do_reset();
  endtask

  task automatic test_single_load();
    set_req(1, 1'b0, 32'h40, 32'h0);
    tick(); clr_req();
    checks++;
    if (bus.r1_busy !== 1'b1 || bus.m_req !== 1'b0) begin
      errors++; $display("FAIL load_capture: got busy=%b req=%b expected busy=1 req=0", bus.r1_busy, bus.m_req);
    end
    tick();
    checks++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h40 || bus.m_we !== 1'b0) begin
      errors++; $display("FAIL load_mreq: got req=%b addr=%h we=%b expected req=1 addr=00000040 we=0", bus.m_req, bus.m_addr, bus.m_we);
    end
    bus.m_gnt = 1;
    tick(); bus.m_gnt = 0;
    checks++;
    if (bus.m_req !== 1'b0 || bus.r1_ack !== 1'b0) begin
      errors++; $display("FAIL load_wait: got req=%b ack=%b expected req=0 ack=0", bus.m_req, bus.r1_ack);
    end
    bus.m_rvalid = 1; bus.m_rdata = 32'hDEAD_BEEF;
    tick(); bus.m_rvalid = 0; bus.m_rdata = '0;
    checks++;
    if (bus.r1_ack !== 1'b1 || bus.r1_rdata !== 32'hDEAD_BEEF || bus.r1_err !== 1'b0 || bus.r0_ack !== 1'b0) begin
      errors++; $display("FAIL load_ack: got ack=%b rdata=%h err=%b ack0=%b expected ack=1 rdata=deadbeef err=0 ack0=0",
        bus.r1_ack, bus.r1_rdata, bus.r1_err, bus.r0_ack);
    end
    tick();
    checks++;
    if (bus.r1_ack !== 1'b0 || bus.r1_busy !== 1'b0 || bus.r1_rdata !== 32'h0) begin
      errors++; $display("FAIL load_done: got ack=%b busy=%b rdata=%h expected 0 0 0", bus.r1_ack, bus.r1_busy, bus.r1_rdata);
    end
  endtask

  task automatic test_contention();
    do_reset();
    set_req(0, 1'b1, 32'h10, 32'h5);
    set_req(1, 1'b0, 32'h20, 32'h0);
    tick(); clr_req();
    tick();
    checks++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h10 || bus.m_we !== 1'b1 || bus.m_wdata !== 32'h5) begin
      errors++; $display("FAIL cont_first: got req=%b addr=%h we=%b wdata=%h expected 1 00000010 1 00000005",
        bus.m_req, bus.m_addr, bus.m_we, bus.m_wdata);
    end
    bus.m_gnt = 1;
    tick(); bus.m_gnt = 0;
    checks++;
    if (bus.r0_ack !== 1'b1 || bus.r0_rdata !== 32'h0 || bus.r0_err !== 1'b0 || bus.r1_ack !== 1'b0 || bus.m_req !== 1'b0) begin
      errors++; $display("FAIL cont_ack0: got ack0=%b rdata=%h err=%b ack1=%b req=%b expected 1 0 0 0 0",
        bus.r0_ack, bus.r0_rdata, bus.r0_err, bus.r1_ack, bus.m_req);
    end
    tick();
    checks++;
    if (bus.m_req !== 1'b0 || bus.r0_ack !== 1'b0) begin
      errors++; $display("FAIL cont_gap: got req=%b ack0=%b expected 0 0", bus.m_req, bus.r0_ack);
    end
    tick();
    checks++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h20 || bus.m_we !== 1'b0) begin
      errors++; $display("FAIL cont_second: got req=%b addr=%h we=%b expected 1 00000020 0", bus.m_req, bus.m_addr, bus.m_we);
    end
    bus.m_gnt = 1;
    tick(); bus.m_gnt = 0;
    bus.m_rvalid = 1; bus.m_rdata = 32'h1234_5678;
    tick(); bus.m_rvalid = 0;
    checks++;
    if (bus.r1_ack !== 1'b1 || bus.r1_rdata !== 32'h1234_5678 || bus.r0_ack !== 1'b0) begin
      errors++; $display("FAIL cont_ack1: got ack1=%b rdata=%h ack0=%b expected 1 12345678 0", bus.r1_ack, bus.r1_rdata, bus.r0_ack);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int p;
    int waited;
    // last_gnt is 1 after the contention test, so port 0 leads.
    set_req(0, 1'b1, 32'h100, 32'hA0);
    set_req(1, 1'b1, 32'h200, 32'hB0);
    tick(); clr_req();
    for (int n = 0; n < 8; n++) begin
      p = n % 2;
      waited = 0;
      while (!bus.m_req && waited < 20) begin
        tick();
        waited++;
      end
      checks++;
      if (bus.m_req !== 1'b1) begin
        errors++; $display("FAIL fair_timeout_%0d: got req=%b expected 1 within 20 cycles", n, bus.m_req);
        break;
      end
      checks++;
      if (bus.m_addr[9] !== p[0]) begin
        errors++; $display("FAIL fair_grant_%0d: got port %0d expected port %0d", n, bus.m_addr[9], p);
      end
      bus.m_gnt = 1;
      tick(); bus.m_gnt = 0;
      checks++;
      if ((p == 0 ? {bus.r1_ack, bus.r0_ack} : {bus.r0_ack, bus.r1_ack}) !== 2'b01) begin
        errors++; $display("FAIL fair_ack_%0d: got ack1=%b ack0=%b expected only port %0d", n, bus.r1_ack, bus.r0_ack, p);
      end
      tick();
      set_req(p, 1'b1, (p == 0 ? 32'h100 : 32'h200) + 32'(n + 1), 32'(n));
      tick(); clr_req();
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int a0;
    set_req(0, 1'b0, 32'h30, 32'h0);
    tick(); clr_req();
    tick();
    checks++;
    if (bus.m_req !== 1'b1) begin
      errors++; $display("FAIL tmo_rise: got req=%b expected 1", bus.m_req);
    end
    repeat (7) tick();
    checks++;
    if (bus.m_req !== 1'b1 || bus.r0_ack !== 1'b0) begin
      errors++; $display("FAIL tmo_early: got req=%b ack=%b expected req=1 ack=0", bus.m_req, bus.r0_ack);
    end
    bus.m_gnt = 1;
    tick(); bus.m_gnt = 0;
    checks++;
    if (bus.m_req !== 1'b0 || bus.r0_ack !== 1'b1 || bus.r0_err !== 1'b1 || bus.r0_rdata !== 32'h0) begin
      errors++; $display("FAIL tmo_ack: got req=%b ack=%b err=%b rdata=%h expected 0 1 1 0",
        bus.m_req, bus.r0_ack, bus.r0_err, bus.r0_rdata);
    end
    bus.m_rvalid = 1; bus.m_rdata = 32'h0BAD_0BAD;
    tick(); bus.m_rvalid = 0; bus.m_rdata = '0;
    a0 = ack_cnt0;
    checks++;
    if (bus.r0_ack !== 1'b0 || bus.r0_err !== 1'b0 || bus.r0_busy !== 1'b0) begin
      errors++; $display("FAIL tmo_after: got ack=%b err=%b busy=%b expected 0 0 0", bus.r0_ack, bus.r0_err, bus.r0_busy);
    end
    repeat (3) tick();
    checks++;
    if (ack_cnt0 !== a0 || bus.m_req !== 1'b0) begin
      errors++; $display("FAIL tmo_late_rvalid: got acks=%0d req=%b expected acks=%0d req=0", ack_cnt0, bus.m_req, a0);
    end
  endtask

  task automatic test_busy_violation();
    int busy_reqs;
    set_req(1, 1'b0, 32'h50, 32'h0);
    tick();
    checks++;
    if (bus.r1_busy !== 1'b1) begin
      errors++; $display("FAIL busy_set: got busy=%b expected 1", bus.r1_busy);
    end
    set_req(1, 1'b1, 32'h99, 32'h77);
    tick(); clr_req();
    checks++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h50 || bus.m_we !== 1'b0) begin
      errors++; $display("FAIL busy_orig: got req=%b addr=%h we=%b expected 1 00000050 0", bus.m_req, bus.m_addr, bus.m_we);
    end
    bus.m_gnt = 1;
    tick(); bus.m_gnt = 0;
    bus.m_rvalid = 1; bus.m_rdata = 32'hCAFE_F00D;
    tick(); bus.m_rvalid = 0;
    checks++;
    if (bus.r1_ack !== 1'b1 || bus.r1_rdata !== 32'hCAFE_F00D || bus.r1_err !== 1'b0) begin
      errors++; $display("FAIL busy_ack: got ack=%b rdata=%h err=%b expected 1 cafef00d 0", bus.r1_ack, bus.r1_rdata, bus.r1_err);
    end
    // A strobe during the ack cycle still sees busy=1 and must be dropped.
    set_req(1, 1'b1, 32'h99, 32'h77);
    tick(); clr_req();
    checks++;
    if (bus.r1_busy !== 1'b0) begin
      errors++; $display("FAIL busy_clear: got busy=%b expected 0", bus.r1_busy);
    end
    busy_reqs = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.m_req) busy_reqs++;
    end
    checks++;
    if (busy_reqs !== 0) begin
      errors++; $display("FAIL busy_no_reissue: got %0d request cycles expected 0", busy_reqs);
    end
  endtask

  initial begin
    clear_inputs();
    do_reset();
    test_reset();
    test_single_load();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_busy_violation();
    checks++;
    if (both_ack !== 0) begin
      errors++; $display("FAIL ack_exclusive: got %0d dual-ack cycles expected 0", both_ack);
    end
    checks++;
    if (seen_99 !== 1'b0) begin
      errors++; $display("FAIL addr_99_issued: got %b expected 0", seen_99);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
